mem_stage_dmem_if: RTL and testbench
====================================

// Module: mem_stage_dmem_if
// PURPOSE
//  MEM-stage data-memory interface; consumes instructions leaving the AGEX latch.
//  - Loads: handshakes a request, waits for the response and returns the load data.
//  - Stores: handshakes the write request; no response is expected.
//  - Non-memory ops: pass aluout through unchanged.
//  Stalls AGEX while a memory access is outstanding and delivers one registered
//  result per retired instruction to WB. Also drives hazard info back to DE.
// PARAMETERS
//  DBITS    32  data/address width
//  REGNOBITS 5  register-number width
//  TIMEOUT  64  max cycles in WAIT before the response is abandoned (>=2)
// PORTS
//  clk            in  1         pipeline clock
//  reset          in  1         synchronous, active-low reset
//  in_valid       in  1         AGEX presents an instruction
//  in_ready       out 1         block can accept; AGEX stalls while 0
//  in_is_load     in  1         instruction is LW
//  in_wr_mem      in  1         instruction is SW
//  in_aluout      in  DBITS     ALU result / effective address
//  in_wr_val      in  DBITS     store data
//  in_rd          in  REGNOBITS destination register
//  in_wr_reg      in  1         instruction writes rd
//  in_pc          in  DBITS     instruction PC
//  dmem_req_valid out 1         request valid
//  dmem_req_ready in  1         memory accepts request
//  dmem_req_we    out 1         1=store, 0=load
//  dmem_req_addr  out DBITS     word-aligned address
//  dmem_req_wdata out DBITS     store data
//  dmem_rsp_valid in  1         load data valid
//  dmem_rsp_rdata in  DBITS     load data
//  out_valid      out 1         one-cycle pulse: result for WB
//  out_rd         out REGNOBITS destination register
//  out_wr_reg     out 1         WB must write out_rd
//  out_wdata      out DBITS     value to write
//  out_pc         out DBITS     PC of retiring instruction
//  fwd_busy       out 1         memory op in flight (REQ/WAIT)
//  fwd_rd         out REGNOBITS rd of in-flight op (valid when fwd_busy)
//  err_misalign   out 1         sticky; set on a misaligned access
//  err_timeout    out 1         sticky; set when a load response times out
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE; every output register and the timeout
//   counter go to 0; both err flags clear; in_ready=1 on the first cycle after reset.
//  FSM states: IDLE, REQ, WAIT.
//   in_ready=1 only in IDLE. Acceptance = posedge with in_valid & in_ready.
//  IDLE, accept non-memory op: next cycle out_valid=1, out_wdata=in_aluout,
//   out_wr_reg=in_wr_reg; state stays IDLE (1-cycle latency, back-to-back capable).
//  IDLE, accept load/store with in_aluout[1:0]!=0: no request issued;
//   err_misalign<=1; next cycle out_valid=1 with out_wr_reg=0.
//  IDLE, accept aligned load/store: capture addr/wdata/rd/pc; go to REQ.
//  REQ: dmem_req_valid=1 (combinational from state); address/data/we held stable.
//   When dmem_req_ready=1 at a posedge:
//   - store: out_valid=1 next cycle with out_wr_reg=0; go to IDLE.
//   - load: clear timeout counter; go to WAIT.
//  WAIT: counter increments each cycle.
//   - dmem_rsp_valid=1 at a posedge: out_valid=1 next cycle, out_wdata=dmem_rsp_rdata,
//     out_wr_reg=captured wr_reg; go to IDLE.
//   - Counter reaches TIMEOUT-1 with no response: err_timeout<=1; out_valid=1 with
//     out_wr_reg=0; go to IDLE.
//   - rsp_valid and timeout on the same edge: the response wins.
//  dmem_rsp_valid outside WAIT is ignored (covers late responses after a timeout).
//  out_valid is high for exactly one cycle per accepted instruction, in program order.
//  fwd_busy=1 in REQ/WAIT; fwd_rd=captured rd in those states, else 0.
//  Reset in REQ/WAIT: abandon the access; IDLE next cycle; dmem_req_valid=0; no out_valid.
// TESTING
//  ADD: in_aluout=0x1234, rd=5, wr_reg=1 -> next cycle out_valid, out_wdata=0x1234, out_rd=5.
//  LW @0x100, req_ready=1, rsp 2 cycles later rdata=0xCAFEF00D -> out_wdata=0xCAFEF00D;
//   in_ready=0 throughout.
//  SW @0x80 val=0x55, req_ready low for 3 cycles -> req_valid/addr/wdata stable 4 cycles;
//   then out_valid with out_wr_reg=0.
//  LW @0x102 -> no dmem_req_valid; err_misalign=1; out_valid with out_wr_reg=0.
//  LW, no response for TIMEOUT cycles -> err_timeout=1; IDLE; a late rsp_valid is ignored.
//  reset=0 while in WAIT -> next cycle IDLE, in_ready=1, flags=0, no out_valid pulse.

Source files
------------

// File: rtl/mem_stage_dmem_if.sv
// MEM-stage data-memory interface: non-memory ops retire 1 cycle after acceptance, memory ops retire 1 cycle after the req/rsp handshake or the timeout.
// Backpressure: in_ready drops while an access is in REQ/WAIT; the request is held stable until dmem_req_ready.
module mem_stage_dmem_if #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_is_load,
  input  logic                 in_wr_mem,
  input  logic [DBITS-1:0]     in_aluout,
  input  logic [DBITS-1:0]     in_wr_val,
  input  logic [REGNOBITS-1:0] in_rd,
  input  logic                 in_wr_reg,
  input  logic [DBITS-1:0]     in_pc,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic                 dmem_req_we,
  output logic [DBITS-1:0]     dmem_req_addr,
  output logic [DBITS-1:0]     dmem_req_wdata,
  input  logic                 dmem_rsp_valid,
  input  logic [DBITS-1:0]     dmem_rsp_rdata,
  output logic                 out_valid,
  output logic [REGNOBITS-1:0] out_rd,
  output logic                 out_wr_reg,
  output logic [DBITS-1:0]     out_wdata,
  output logic [DBITS-1:0]     out_pc,
  output logic                 fwd_busy,
  output logic [REGNOBITS-1:0] fwd_rd,
  output logic                 err_misalign,
  output logic                 err_timeout
);

  localparam int CBITS = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic [CBITS-1:0]     cnt_q, cnt_d;
  logic                 req_we_q, req_we_d;
  logic [DBITS-1:0]     req_addr_q, req_addr_d;
  logic [DBITS-1:0]     req_wdata_q, req_wdata_d;
  logic [REGNOBITS-1:0] cap_rd_q, cap_rd_d;
  logic                 cap_wr_reg_q, cap_wr_reg_d;
  logic [DBITS-1:0]     cap_pc_q, cap_pc_d;
  logic                 out_valid_q, out_valid_d;
  logic [REGNOBITS-1:0] out_rd_q, out_rd_d;
  logic                 out_wr_reg_q, out_wr_reg_d;
  logic [DBITS-1:0]     out_wdata_q, out_wdata_d;
  logic [DBITS-1:0]     out_pc_q, out_pc_d;
  logic                 err_mis_q, err_mis_d;
  logic                 err_to_q, err_to_d;
  logic                 in_is_mem;

  assign in_is_mem = in_is_load | in_wr_mem;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    cap_rd_d     = cap_rd_q;
    cap_wr_reg_d = cap_wr_reg_q;
    cap_pc_d     = cap_pc_q;
    out_valid_d  = 1'b0;
    out_rd_d     = out_rd_q;
    out_wr_reg_d = out_wr_reg_q;
    out_wdata_d  = out_wdata_q;
    out_pc_d     = out_pc_q;
    err_mis_d    = err_mis_q;
    err_to_d     = err_to_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_is_mem && (in_aluout[1:0] == 2'b00)) begin
            req_we_d     = in_wr_mem;
            req_addr_d   = in_aluout;
            req_wdata_d  = in_wr_val;
            cap_rd_d     = in_rd;
            cap_wr_reg_d = in_wr_reg;
            cap_pc_d     = in_pc;
            state_d      = S_REQ;
          end else begin
            // Misaligned memory ops retire immediately without touching memory.
            out_valid_d  = 1'b1;
            out_rd_d     = in_rd;
            out_wr_reg_d = in_wr_reg & ~in_is_mem;
            out_wdata_d  = in_aluout;
            out_pc_d     = in_pc;
            if (in_is_mem) err_mis_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (dmem_req_ready) begin
          if (req_we_q) begin
            out_valid_d  = 1'b1;
            out_rd_d     = cap_rd_q;
            out_wr_reg_d = 1'b0;
            out_wdata_d  = req_wdata_q;
            out_pc_d     = cap_pc_q;
            state_d      = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CBITS'(1);
        if (dmem_rsp_valid) begin
          out_valid_d  = 1'b1;
          out_rd_d     = cap_rd_q;
          out_wr_reg_d = cap_wr_reg_q;
          out_wdata_d  = dmem_rsp_rdata;
          out_pc_d     = cap_pc_q;
          state_d      = S_IDLE;
        end else if (cnt_q == CBITS'(TIMEOUT - 1)) begin
          out_valid_d  = 1'b1;
          out_rd_d     = cap_rd_q;
          out_wr_reg_d = 1'b0;
          out_wdata_d  = '0;
          out_pc_d     = cap_pc_q;
          err_to_d     = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      cap_rd_q     <= '0;
      cap_wr_reg_q <= 1'b0;
      cap_pc_q     <= '0;
      out_valid_q  <= 1'b0;
      out_rd_q     <= '0;
      out_wr_reg_q <= 1'b0;
      out_wdata_q  <= '0;
      out_pc_q     <= '0;
      err_mis_q    <= 1'b0;
      err_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      cap_rd_q     <= cap_rd_d;
      cap_wr_reg_q <= cap_wr_reg_d;
      cap_pc_q     <= cap_pc_d;
      out_valid_q  <= out_valid_d;
      out_rd_q     <= out_rd_d;
      out_wr_reg_q <= out_wr_reg_d;
      out_wdata_q  <= out_wdata_d;
      out_pc_q     <= out_pc_d;
      err_mis_q    <= err_mis_d;
      err_to_q     <= err_to_d;
    end
  end

  assign in_ready       = (state_q == S_IDLE);
  assign dmem_req_valid = (state_q == S_REQ);
  assign dmem_req_we    = req_we_q;
  assign dmem_req_addr  = req_addr_q;
  assign dmem_req_wdata = req_wdata_q;
  assign out_valid      = out_valid_q;
  assign out_rd         = out_rd_q;
  assign out_wr_reg     = out_wr_reg_q;
  assign out_wdata      = out_wdata_q;
  assign out_pc         = out_pc_q;
  assign fwd_busy       = (state_q != S_IDLE);
  assign fwd_rd         = fwd_busy ? cap_rd_q : '0;
  assign err_misalign   = err_mis_q;
  assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_mem_stage_dmem_if.sv
// Bench for mem_stage_dmem_if: directed scenarios then random instructions against a word-memory model.
module tb_mem_stage_dmem_if;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_is_load = 1'b0, in_wr_mem = 1'b0, in_wr_reg = 1'b0;
  logic        in_ready;
  logic [31:0] in_aluout = '0, in_wr_val = '0, in_pc = '0;
  logic [4:0]  in_rd = '0;
  logic        dmem_req_valid, dmem_req_we;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rsp_rdata = '0;
  logic        out_valid, out_wr_reg, fwd_busy, err_misalign, err_timeout;
  logic [4:0]  out_rd, fwd_rd;
  logic [31:0] out_wdata, out_pc;

  int tests = 0;
  int failed = 0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];
  bit exp_mis = 0, exp_to = 0;

  mem_stage_dmem_if #(.DBITS(32), .REGNOBITS(5), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load), .in_wr_mem(in_wr_mem),
    .in_aluout(in_aluout), .in_wr_val(in_wr_val), .in_rd(in_rd), .in_wr_reg(in_wr_reg), .in_pc(in_pc),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .out_valid(out_valid), .out_rd(out_rd), .out_wr_reg(out_wr_reg), .out_wdata(out_wdata), .out_pc(out_pc),
    .fwd_busy(fwd_busy), .fwd_rd(fwd_rd), .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Unwritten words read back as a fixed hash of their address.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic idle_cycle(input bit late_rsp);
    in_valid = 1'b0;
    dmem_rsp_valid = late_rsp;
    dmem_rsp_rdata = $urandom;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_req_valid", 32'(dmem_req_valid), 32'd0);
  endtask

  // rsp_wait: WAIT cycles before the response appears; negative means never.
  task automatic run_instr(input bit ld, input bit st, input logic [31:0] alu, input logic [31:0] wv,
                           input logic [4:0] rd, input bit wr, input logic [31:0] pc,
                           input int req_wait, input int rsp_wait);
    logic [31:0] exp_wd, baddr, bwd;
    bit exp_wr, chk_wd, is_mem, resp;
    exp_wd = '0; exp_wr = 0; chk_wd = 0; resp = 0; baddr = '0; bwd = '0;
    chk("accept_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_is_load = ld; in_wr_mem = st; in_aluout = alu;
    in_wr_val = wv; in_rd = rd; in_wr_reg = wr; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    is_mem = ld | st;
    if (!is_mem) begin
      exp_wd = alu; exp_wr = wr; chk_wd = 1;
    end else if (alu[1:0] != 2'b00) begin
      exp_wr = 0; exp_mis = 1;
    end else begin
      for (int i = 0; i <= req_wait; i++) begin
        @(negedge clk);
        chk("req_valid", 32'(dmem_req_valid), 32'd1);
        chk("req_addr", dmem_req_addr, alu);
        chk("req_we", 32'(dmem_req_we), 32'(st));
        if (st) chk("req_wdata", dmem_req_wdata, wv);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        chk("busy_out_valid", 32'(out_valid), 32'd0);
        chk("req_fwd_busy", 32'(fwd_busy), 32'd1);
        chk("req_fwd_rd", 32'(fwd_rd), 32'(rd));
        baddr = dmem_req_addr; bwd = dmem_req_wdata;
        if (i == req_wait) dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
      end
      if (st) begin
        bus_mem[baddr] = bwd;
        ref_mem[alu] = wv;
        exp_wr = 0;
      end else begin
        for (int c = 0; c < TMO; c++) begin
          @(negedge clk);
          chk("wait_req_valid", 32'(dmem_req_valid), 32'd0);
          chk("wait_out_valid", 32'(out_valid), 32'd0);
          chk("wait_in_ready", 32'(in_ready), 32'd0);
          chk("wait_fwd_rd", 32'(fwd_rd), 32'(rd));
          if (c == rsp_wait) begin
            dmem_rsp_valid = 1'b1;
            dmem_rsp_rdata = bus_mem.exists(baddr) ? bus_mem[baddr] : dflt(baddr);
            resp = 1;
          end
          @(posedge clk); #1;
          dmem_rsp_valid = 1'b0;
          dmem_rsp_rdata = $urandom;
          if (resp) break;
        end
        if (rsp_wait >= 0 && rsp_wait < TMO) begin
          exp_wd = ref_mem.exists(alu) ? ref_mem[alu] : dflt(alu);
          exp_wr = wr; chk_wd = 1;
        end else begin
          exp_wr = 0; exp_to = 1;
        end
      end
    end
    @(negedge clk);
    chk("ret_out_valid", 32'(out_valid), 32'd1);
    chk("ret_out_rd", 32'(out_rd), 32'(rd));
    chk("ret_out_pc", out_pc, pc);
    chk("ret_out_wr_reg", 32'(out_wr_reg), 32'(exp_wr));
    if (chk_wd) chk("ret_out_wdata", out_wdata, exp_wd);
    chk("ret_err_misalign", 32'(err_misalign), 32'(exp_mis));
    chk("ret_err_timeout", 32'(err_timeout), 32'(exp_to));
    chk("ret_req_valid", 32'(dmem_req_valid), 32'd0);
    chk("ret_fwd_busy", 32'(fwd_busy), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_wdata"}, out_wdata, 32'd0);
    chk({tag, "_out_rd"}, 32'(out_rd), 32'd0);
    chk({tag, "_out_wr_reg"}, 32'(out_wr_reg), 32'd0);
    chk({tag, "_out_pc"}, out_pc, 32'd0);
    chk({tag, "_req_valid"}, 32'(dmem_req_valid), 32'd0);
    chk({tag, "_fwd_busy"}, 32'(fwd_busy), 32'd0);
    chk({tag, "_fwd_rd"}, 32'(fwd_rd), 32'd0);
    chk({tag, "_err_misalign"}, 32'(err_misalign), 32'd0);
    chk({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  // Start an aligned load to rd=9, optionally push it into WAIT, then reset it.
  task automatic reset_mid_access(input bit into_wait, input string tag);
    in_valid = 1'b1; in_is_load = 1'b1; in_wr_mem = 1'b0; in_aluout = 32'h200;
    in_rd = 5'd9; in_wr_reg = 1'b1; in_pc = 32'h4000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (into_wait) begin
      dmem_req_ready = 1'b1;
      @(posedge clk); #1;
      dmem_req_ready = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_pre_busy"}, 32'(fwd_busy), 32'd1);
    chk({tag, "_pre_req_valid"}, 32'(dmem_req_valid), 32'(!into_wait));
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_mis = 0; exp_to = 0;
    @(negedge clk);
    check_reset_state(tag);
  endtask

  initial begin
    int k, rw, sw;
    bit ld, st;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_reset_state("por");

    ref_mem[32'h100] = 32'hCAFEF00D;
    bus_mem[32'h100] = 32'hCAFEF00D;
    run_instr(0, 0, 32'h1234, 32'h0, 5'd5, 1, 32'h1000, 0, 0);
    run_instr(0, 0, 32'h5678, 32'h0, 5'd6, 1, 32'h1004, 0, 0);
    run_instr(1, 0, 32'h100, 32'h0, 5'd7, 1, 32'h1008, 0, 2);
    run_instr(0, 1, 32'h80, 32'h55, 5'd0, 0, 32'h100C, 3, 0);
    run_instr(1, 0, 32'h80, 32'h0, 5'd8, 1, 32'h1010, 1, 0);
    idle_cycle(0);
    run_instr(1, 0, 32'h102, 32'h0, 5'd3, 1, 32'h1014, 0, 0);
    run_instr(1, 0, 32'h104, 32'h0, 5'd4, 1, 32'h1018, 0, TMO - 1);
    run_instr(1, 0, 32'h108, 32'h0, 5'd10, 1, 32'h101C, 0, -1);
    idle_cycle(1);
    idle_cycle(0);
    reset_mid_access(1, "rst_wait");
    reset_mid_access(0, "rst_req");

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 3);
      a = 32'h100 + 32'($urandom_range(0, 15) << 2);
      rw = $urandom_range(0, 3);
      sw = $urandom_range(0, 9);
      sw = (sw == 0) ? -1 : (sw == 1) ? TMO - 1 : $urandom_range(0, 4);
      ld = (k == 1) || (k == 3 && $urandom_range(0, 1) == 1);
      st = (k == 2) || (k == 3 && !ld);
      if (k == 0) a = $urandom;
      if (k == 3) a = a | 32'($urandom_range(1, 3));
      run_instr(ld, st, a, $urandom, 5'($urandom), 1'($urandom), $urandom, rw, sw);
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
